bias_group_sequencer: RTL

Sequences the per-layer bias constant banks against the adder-tree output stream for one convolution layer. Accumulates N_ACC adder-tree beats per output-channel group, then adds that group's bias bank with saturation. It emits one biased 16-lane vector per group and steps through all N_GROUPS banks (e.g. the four 16-lane banks of a layer) before signalling done. It sits between the adder tree and the activation/requantisation stage.

---
 rtl/bias_group_sequencer_if.sv | 30 +++
 rtl/bias_group_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/bias_group_sequencer_if.sv
// Adder-tree beat stream in, biased group vector out; both valid/ready.
// The sequencer takes the slave side and the producer/consumer pair takes the master side.
interface bias_group_sequencer_if #(
  parameter int LANES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*18-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*18-1:0]   out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/bias_group_sequencer.sv
// Adds each group's bias bank to N_ACC saturating-accumulated adder-tree beats; out_valid 1 cycle after the
// last beat, held (in_ready=0) until out_ready; done pulses once after the final group is taken.
module bias_group_sequencer #(
  parameter int N_adder_tree = 16,
  parameter int N_GROUPS     = 4,
  parameter int N_ACC        = 9,
  localparam int GW          = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [N_GROUPS*N_adder_tree*18-1:0] bias_bus,
  bias_group_sequencer_if.slave              bus,
  output logic [GW-1:0]                      group_idx,
  output logic                               busy,
  output logic                               done
);

  localparam int BW = N_adder_tree * 18;
  localparam int CW = $clog2(N_ACC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [CW-1:0] LAST_BEAT  = CW'(N_ACC - 1);
  localparam logic [GW-1:0] LAST_GROUP = GW'(N_GROUPS - 1);

  logic [1:0]          state;
  logic [CW-1:0]       beat_cnt;
  logic signed [17:0]  acc [N_adder_tree];
  logic [BW-1:0]       bank;
  logic                beat_take;

  // 19-bit sum clamped back into 18-bit two's complement.
  function automatic logic signed [17:0] sat18(input logic signed [17:0] a,
                                               input logic signed [17:0] b);
    logic signed [18:0] s;
    s = {a[17], a} + {b[17], b};
    if (s[18] != s[17])
      sat18 = s[18] ? 18'sh20000 : 18'sh1FFFF;
    else
      sat18 = s[17:0];
  endfunction

  always_comb begin
    bank = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (group_idx == GW'(g))
        bank = bias_bus[g*BW +: BW];
    end
  end

  assign beat_take     = (state == S_ACCUM) && bus.in_valid;
  assign bus.in_ready  = (state == S_ACCUM);
  assign bus.out_valid = (state == S_HOLD);
  assign busy          = (state != S_IDLE);

  // The first beat of a group seeds the accumulator from the bias bank instead of acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_adder_tree; i++)
        acc[i] <= '0;
    end else if (beat_take) begin
      for (int i = 0; i < N_adder_tree; i++)
        acc[i] <= sat18((beat_cnt == '0) ? bank[18*i +: 18] : acc[i],
                        bus.in_data[18*i +: 18]);
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_pack
    assign bus.out_data[18*i +: 18] = acc[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      group_idx <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ACCUM;
            group_idx <= '0;
            beat_cnt  <= '0;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (beat_cnt == LAST_BEAT)
              state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            beat_cnt <= '0;
            if (group_idx == LAST_GROUP) begin
              group_idx <= '0;
              state     <= S_IDLE;
              done      <= 1'b1;
            end else begin
              group_idx <= group_idx + GW'(1);
              state     <= S_ACCUM;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
